// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int MAX_LEN   = 63;
  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int LEN_LSB   = 2;
  localparam int BUF_DEPTH = 64;
  localparam int PTR_W     = 6;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_CHECK
  } tx_state_e;

  // Header byte: payload length in the upper bits, destination port in the lower bits.
  function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                             input logic [ADDR_W-1:0] addr);
    logic [7:0] h;
    h = '0;
    h[LEN_LSB +: LEN_W] = len;
    h[ADDR_W-1:0]       = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8, one write port, one registered read port.
// rd_data_o always holds the byte at the current read pointer, so the next
// byte is ready the moment the current one transfers.
module router_tx_buf
  import router_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [7:0]       wr_data_i,
  input  logic             re_i,
  output logic [7:0]       rd_data_o,
  output logic [PTR_W-1:0] wr_ptr_o
);

  logic [7:0]       mem [0:BUF_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       rd_data_q;

  // Pointer next-state: clear wins, otherwise advance on each access.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (we_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (re_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage array write; contents need no reset since pointers gate use.
  always_ff @(posedge clk) begin
    if (we_i) mem[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and registered read; a same-cycle write to the read slot is forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= (we_i && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem[rd_ptr_d];
    end
  end

  assign rd_data_o = rd_data_q;
  assign wr_ptr_o  = wr_ptr_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 1x3 router input: buffers a payload, then
// sends header, payload and parity under busy back-pressure and reports the
// router's parity verdict.
// Handshake: a request/payload byte is taken on a rising edge where both
// valid and ready are high; an output byte is taken by the router on a rising
// edge where busy is low, and data_out/pkt_valid hold while busy is high.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [7:0]        pld_data,
  input  logic              busy,
  input  logic              error,
  output logic [7:0]        data_out,
  output logic              pkt_valid,
  output logic              done,
  output logic              err_flag,
  output logic              reject,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]  idx_q, idx_d;
  logic [7:0]        parity_q, parity_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [1:0]        chk_q, chk_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              done_q, done_d;
  logic              err_flag_q, err_flag_d;
  logic              reject_q, reject_d;
  logic              timeout_q, timeout_d;

  logic              buf_clr, buf_we, buf_re;
  logic [7:0]        buf_rd_data;
  logic [PTR_W-1:0]  buf_wr_ptr;
  logic              sending;

  router_tx_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (buf_clr),
    .we_i      (buf_we),
    .wr_data_i (pld_data),
    .re_i      (buf_re),
    .rd_data_o (buf_rd_data),
    .wr_ptr_o  (buf_wr_ptr)
  );

  assign sending = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) ||
                   (state_q == ST_PARITY);

  // Next-state and output-register logic for the transmit FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    busy_cnt_d  = '0;
    chk_d       = chk_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    err_flag_d  = err_flag_q;
    reject_d    = 1'b0;
    timeout_d   = 1'b0;
    buf_clr     = 1'b0;
    buf_we      = 1'b0;
    buf_re      = 1'b0;

    if (sending && busy) busy_cnt_d = busy_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if ((req_addr == ADDR_INVALID) || (req_len == '0)) begin
            reject_d = 1'b1;
          end else begin
            addr_d   = req_addr;
            len_d    = req_len;
            buf_clr  = 1'b1;
            parity_d = make_header(req_len, req_addr);
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (pld_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ pld_data;
          if (buf_wr_ptr == len_q - LEN_W'(1)) begin
            data_out_d  = make_header(len_q, addr_q);
            pkt_valid_d = 1'b1;
            state_d     = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          buf_re     = 1'b1;
          data_out_d = buf_rd_data;
          idx_d      = '0;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            data_out_d  = parity_q;
            pkt_valid_d = 1'b0;
            state_d     = ST_PARITY;
          end else begin
            buf_re     = 1'b1;
            data_out_d = buf_rd_data;
            idx_d      = idx_q + PTR_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          data_out_d = '0;
          chk_d      = '0;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        chk_d = chk_q + 2'd1;
        if (chk_q == 2'd1) begin
          done_d     = 1'b1;
          err_flag_d = error;
        end
        if (chk_q == 2'd2) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Router stuck busy too long: drop the packet and return to idle.
    if (sending && busy && (busy_cnt_q == CNT_W'(BUSY_TIMEOUT - 1))) begin
      state_d     = ST_IDLE;
      data_out_d  = '0;
      pkt_valid_d = 1'b0;
      timeout_d   = 1'b1;
      busy_cnt_d  = '0;
      buf_clr     = 1'b1;
      buf_re      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      parity_q    <= '0;
      busy_cnt_q  <= '0;
      chk_q       <= '0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      busy_cnt_q  <= busy_cnt_d;
      chk_q       <= chk_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      err_flag_q  <= err_flag_d;
      reject_q    <= reject_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign pld_ready = (state_q == ST_LOAD);
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign done      = done_q;
  assign err_flag  = err_flag_q;
  assign reject    = reject_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: stimulus and checks happen on the falling
// edge, the DUT acts on the rising edge.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       pld_valid, pld_ready;
  logic [7:0] pld_data;
  logic       busy, error;
  logic [7:0] data_out;
  logic       pkt_valid, done, err_flag, reject, timeout;
  logic [2:0] dbg_state;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] pay [0:63];
  logic [8:0] exp_q [$];
  logic       prev_err;

  router_pkt_tx #(.BUSY_TIMEOUT(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .pld_data  (pld_data),
    .busy      (busy),
    .error     (error),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .done      (done),
    .err_flag  (err_flag),
    .reject    (reject),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue a request and load its payload; returns in the header cycle with
  // the expected output stream (header, payload, parity) in exp_q.
  task automatic load_pkt(input logic [1:0] addr, input logic [5:0] len);
    logic [7:0] par;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    check("pld_ready_load", pld_ready, 1);
    par = {len, addr};
    exp_q.delete();
    exp_q.push_back({1'b1, par});
    for (int i = 0; i < int'(len); i++) begin
      pld_valid = 1'b1;
      pld_data  = pay[i];
      par       = par ^ pay[i];
      exp_q.push_back({1'b1, pay[i]});
      @(negedge clk);
    end
    pld_valid = 1'b0;
    exp_q.push_back({1'b0, par});
    check("pld_ready_after_load", pld_ready, 0);
  endtask

  // Walk the expected stream, optionally stalling byte stall_k for stall_n
  // cycles, then follow the CHECK phase to the done pulse.
  task automatic stream_pkt(input int stall_k, input int stall_n, input logic err_in);
    logic [8:0] e;
    int k;
    k = 0;
    check("err_flag_held", err_flag, prev_err);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          check($sformatf("hold%0d_%0d", k, s), {pkt_valid, data_out}, e);
          busy = 1'b1;
          @(negedge clk);
        end
        busy = 1'b0;
      end
      check($sformatf("byte%0d", k), {pkt_valid, data_out}, e);
      @(negedge clk);
      k++;
    end
    check("chk_data_zero", {pkt_valid, data_out}, 0);
    check("chk1_done", done, 0);
    check("chk1_req_ready", req_ready, 0);
    error = err_in;
    @(negedge clk);
    check("chk2_done", done, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_err_flag", err_flag, err_in);
    check("done_req_ready", req_ready, 0);
    error = 1'b0;
    @(negedge clk);
    check("done_clear", done, 0);
    check("idle_req_ready", req_ready, 1);
    check("err_flag_after", err_flag, err_in);
    prev_err = err_in;
  endtask

  task automatic bad_req(input logic [1:0] addr, input logic [5:0] len);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    check("reject_pulse", reject, 1);
    check("reject_pld_ready", pld_ready, 0);
    check("reject_pkt_valid", pkt_valid, 0);
    check("reject_req_ready", req_ready, 1);
    @(negedge clk);
    check("reject_clear", reject, 0);
    check("reject_pld_ready2", pld_ready, 0);
    check("reject_pkt_valid2", pkt_valid, 0);
  endtask

  task automatic set_abc();
    pay[0] = 8'hA1;
    pay[1] = 8'hB2;
    pay[2] = 8'hC3;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    pld_valid = 1'b0;
    pld_data  = '0;
    busy      = 1'b0;
    error     = 1'b0;
    prev_err  = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_done", done, 0);
    check("rst_reject", reject, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_pld_ready", pld_ready, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic send: 0D A1 B2 C3 / DD
    set_abc();
    load_pkt(2'd1, 6'd3);
    check("basic_parity", exp_q[exp_q.size()-1], {1'b0, 8'hDD});
    stream_pkt(-1, 0, 1'b0);

    // Busy stall on the header for 3 cycles
    load_pkt(2'd1, 6'd3);
    stream_pkt(0, 3, 1'b0);

    // Busy stall mid-payload
    load_pkt(2'd1, 6'd3);
    stream_pkt(2, 2, 1'b0);

    // Invalid requests
    bad_req(2'd3, 6'd5);
    bad_req(2'd0, 6'd0);

    // Maximum length: FC, 63 x FF, parity 03
    for (int i = 0; i < 63; i++) pay[i] = 8'hFF;
    load_pkt(2'd0, 6'd63);
    check("max_header", exp_q[0], {1'b1, 8'hFC});
    check("max_parity", exp_q[64], {1'b0, 8'h03});
    stream_pkt(-1, 0, 1'b0);

    // Parity error reported, then held until the next done
    pay[0] = 8'h5A;
    load_pkt(2'd2, 6'd1);
    stream_pkt(-1, 0, 1'b1);
    set_abc();
    load_pkt(2'd1, 6'd3);
    stream_pkt(-1, 0, 1'b0);

    // Busy timeout mid-payload
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    load_pkt(2'd2, 6'd4);
    check("to_header", {pkt_valid, data_out}, {1'b1, 8'h12});
    @(negedge clk);
    check("to_byte0", {pkt_valid, data_out}, {1'b1, 8'h11});
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("to_hold%0d", i), {pkt_valid, data_out, timeout}, {1'b1, 8'h22, 1'b0});
      busy = 1'b1;
      @(negedge clk);
    end
    busy = 1'b0;
    check("to_pulse", timeout, 1);
    check("to_pkt_valid", pkt_valid, 0);
    check("to_data_out", data_out, 8'h00);
    check("to_req_ready", req_ready, 1);
    @(negedge clk);
    check("to_clear", timeout, 0);
    check("to_done", done, 0);

    // Recovery send after timeout
    set_abc();
    load_pkt(2'd1, 6'd3);
    stream_pkt(-1, 0, 1'b0);

    // Asynchronous reset mid-payload
    pay[0] = 8'h01;
    load_pkt(2'd0, 6'd3);
    @(negedge clk);
    check("rst_mid_byte0", {pkt_valid, data_out}, {1'b1, 8'h01});
    #2;
    reset = 1'b0;
    #1;
    check("arst_pkt_valid", pkt_valid, 0);
    check("arst_data_out", data_out, 8'h00);
    check("arst_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arst_pkt_valid_after", pkt_valid, 0);
    check("arst_done", done, 0);
    prev_err = 1'b0;

    // Send after reset
    set_abc();
    load_pkt(2'd1, 6'd3);
    stream_pkt(1, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
